// File: rtl/axi2ahb_burst_ctrl_if.sv
// axi2ahb_burst_ctrl_if
//   Bundles the AHB master signals, the command FIFO read side and the
//   read/write data path handshakes of the AXI-to-AHB burst controller.
//   Parameters: ADDR_BITS (HADDR/cmd_addr width), LEN_BITS (cmd_len width).
//   Modports:
//     master - the burst controller (drives HADDR/HTRANS/HBURST/HSIZE/HWRITE,
//              ahb_finish, cmd_err, rdata_phase, wdata_phase, data_last)
//     slave  - the surrounding AHB slave, command FIFO and data paths
interface axi2ahb_burst_ctrl_if #(
    parameter int ADDR_BITS = 32,
    parameter int LEN_BITS  = 8
) ();
    logic [ADDR_BITS-1:0] HADDR;
    logic [1:0]           HTRANS;
    logic [2:0]           HBURST;
    logic [1:0]           HSIZE;
    logic                 HWRITE;
    logic                 HREADY;
    logic [1:0]           HRESP;

    logic                 cmd_empty;
    logic                 cmd_read;
    logic [ADDR_BITS-1:0] cmd_addr;
    logic [LEN_BITS-1:0]  cmd_len;
    logic [1:0]           cmd_size;
    logic                 rdata_ready;
    logic                 wdata_ready;

    logic                 ahb_finish;
    logic                 cmd_err;
    logic                 rdata_phase;
    logic                 wdata_phase;
    logic                 data_last;

    modport master (
        output HADDR, HTRANS, HBURST, HSIZE, HWRITE,
        output ahb_finish, cmd_err, rdata_phase, wdata_phase, data_last,
        input  HREADY, HRESP,
        input  cmd_empty, cmd_read, cmd_addr, cmd_len, cmd_size,
        input  rdata_ready, wdata_ready
    );

    modport slave (
        input  HADDR, HTRANS, HBURST, HSIZE, HWRITE,
        input  ahb_finish, cmd_err, rdata_phase, wdata_phase, data_last,
        output HREADY, HRESP,
        output cmd_empty, cmd_read, cmd_addr, cmd_len, cmd_size,
        output rdata_ready, wdata_ready
    );
endinterface

// File: rtl/axi2ahb_burst_ctrl.sv
// axi2ahb_burst_ctrl
//   AHB master address/control phase generator for the AXI-to-AHB bridge.
//   Takes one queued command at a time and issues it as one or more AHB
//   bursts, splitting at MAX_BEATS and at 1 KB boundaries, with one IDLE
//   cycle between segments. BUSY is issued while the data path stalls
//   mid-burst.
//   Ports:
//     clk   - rising-edge clock
//     reset - synchronous, active-low
//     bus   - axi2ahb_burst_ctrl_if.master (AHB, command FIFO, data paths)
//   Parameters: ADDR_BITS, LEN_BITS, MAX_BEATS (4, 8 or 16).
//   Build option: define AXI2AHB_HRESP_ERR_EN to abort a command on an AHB
//   ERROR response and flag it on cmd_err; otherwise HRESP is ignored.
module axi2ahb_burst_ctrl #(
    parameter int ADDR_BITS = 32,
    parameter int LEN_BITS  = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    axi2ahb_burst_ctrl_if.master bus
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_STALL, S_GAP, S_ERR} state_t;
    typedef enum logic [1:0] {T_IDLE = 2'b00, T_BUSY = 2'b01,
                              T_NONSEQ = 2'b10, T_SEQ = 2'b11} htrans_t;

    localparam int CW = (LEN_BITS + 1 > 11) ? LEN_BITS + 1 : 11;

    state_t               state_q, state_d;
    htrans_t              htrans_q, htrans_d;
    logic [ADDR_BITS-1:0] haddr_q, haddr_d;
    logic [2:0]           hburst_q, hburst_d;
    logic [1:0]           hsize_q, hsize_d;
    logic                 hwrite_q, hwrite_d;
    logic [LEN_BITS:0]    rem_q, rem_d;
    logic [4:0]           seg_left_q, seg_left_d;
    logic                 rphase_q, rphase_d;
    logic                 wphase_q, wphase_d;

    logic                 data_ready;
    logic                 ack;
    logic                 data_last;
    logic                 err_first;
    logic                 finish;
    logic [4:0]           seg;

    // Beats in the next segment: bounded by what is left, by MAX_BEATS and
    // by the distance to the next 1 KB boundary. An unaligned address close
    // to the boundary still gets one beat.
    function automatic logic [4:0] seg_len(input logic [9:0]        addr_lo,
                                           input logic [1:0]        size,
                                           input logic [LEN_BITS:0] rem);
        logic [10:0]   to_kb;
        logic [CW-1:0] len;
        to_kb = (11'd1024 - {1'b0, addr_lo}) >> size;
        if (to_kb == '0) begin
            to_kb = 11'd1;
        end
        len = CW'(rem);
        if (len > CW'(MAX_BEATS)) begin
            len = CW'(MAX_BEATS);
        end
        if (len > CW'(to_kb)) begin
            len = CW'(to_kb);
        end
        return 5'(len);
    endfunction

    function automatic logic [2:0] burst_of(input logic [4:0] n);
        if (n == 5'd1)                          return 3'b000;
        else if (n == 5'd4  && MAX_BEATS >= 4)  return 3'b011;
        else if (n == 5'd8  && MAX_BEATS >= 8)  return 3'b101;
        else if (n == 5'd16 && MAX_BEATS >= 16) return 3'b111;
        else                                    return 3'b001;
    endfunction

    // In IDLE the incoming command selects the data path; afterwards the
    // latched direction does.
    assign data_ready = ((state_q == S_IDLE) ? bus.cmd_read : ~hwrite_q)
                        ? bus.rdata_ready : bus.wdata_ready;
    assign ack        = (htrans_q == T_NONSEQ || htrans_q == T_SEQ) & bus.HREADY;
    assign data_last  = bus.HREADY & (htrans_q == T_IDLE || htrans_q == T_NONSEQ);

`ifdef AXI2AHB_HRESP_ERR_EN
    // First cycle of the two-cycle ERROR response.
    assign err_first  = ~bus.HREADY & (bus.HRESP == 2'b01);
    assign bus.cmd_err = (state_q == S_ERR) & bus.HREADY & reset;
`else
    logic unused_hresp;
    assign unused_hresp = ^bus.HRESP;
    assign err_first    = 1'b0;
    assign bus.cmd_err  = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        htrans_d   = htrans_q;
        haddr_d    = haddr_q;
        hburst_d   = hburst_q;
        hsize_d    = hsize_q;
        hwrite_d   = hwrite_q;
        rem_d      = rem_q;
        seg_left_d = seg_left_q;
        rphase_d   = rphase_q;
        wphase_d   = wphase_q;
        finish     = 1'b0;
        seg        = '0;

        case (state_q)
            S_IDLE: begin
                if (~bus.cmd_empty & data_ready & (bus.HREADY | ~(rphase_q | wphase_q))) begin
                    haddr_d    = bus.cmd_addr;
                    hsize_d    = bus.cmd_size;
                    hwrite_d   = ~bus.cmd_read;
                    rem_d      = {1'b0, bus.cmd_len} + (LEN_BITS+1)'(1);
                    seg        = seg_len(bus.cmd_addr[9:0], bus.cmd_size, rem_d);
                    seg_left_d = seg;
                    hburst_d   = burst_of(seg);
                    htrans_d   = T_NONSEQ;
                    state_d    = S_ADDR;
                end
            end
            S_ADDR: begin
                if (err_first) begin
                    htrans_d = T_IDLE;
                    state_d  = S_ERR;
                end else if (bus.HREADY) begin
                    haddr_d    = haddr_q + (ADDR_BITS'(1) << hsize_q);
                    rem_d      = rem_q - (LEN_BITS+1)'(1);
                    seg_left_d = seg_left_q - 5'd1;
                    if (seg_left_q == 5'd1) begin
                        htrans_d = T_IDLE;
                        if (rem_q > (LEN_BITS+1)'(1)) begin
                            state_d = S_GAP;
                        end else begin
                            haddr_d = '0;
                            finish  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else if (data_ready) begin
                        htrans_d = T_SEQ;
                    end else begin
                        htrans_d = T_BUSY;
                        state_d  = S_STALL;
                    end
                end
            end
            S_STALL: begin
                if (err_first) begin
                    htrans_d = T_IDLE;
                    state_d  = S_ERR;
                end else if (bus.HREADY & data_ready) begin
                    htrans_d = T_SEQ;
                    state_d  = S_ADDR;
                end
            end
            S_GAP: begin
                if (err_first) begin
                    state_d = S_ERR;
                end else if (bus.HREADY) begin
                    seg        = seg_len(haddr_q[9:0], hsize_q, rem_q);
                    seg_left_d = seg;
                    hburst_d   = burst_of(seg);
                    htrans_d   = T_NONSEQ;
                    state_d    = S_ADDR;
                end
            end
            S_ERR: begin
                if (bus.HREADY) begin
                    haddr_d = '0;
                    finish  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                htrans_d = T_IDLE;
            end
        endcase

        // A fresh ack re-arms the flag even when the previous burst's last
        // data phase completes in the same cycle.
        if (ack) begin
            rphase_d = ~hwrite_q;
            wphase_d = hwrite_q;
        end else if (data_last) begin
            rphase_d = 1'b0;
            wphase_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            htrans_q   <= T_IDLE;
            haddr_q    <= '0;
            hburst_q   <= '0;
            hsize_q    <= '0;
            hwrite_q   <= 1'b0;
            rem_q      <= '0;
            seg_left_q <= '0;
            rphase_q   <= 1'b0;
            wphase_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            htrans_q   <= htrans_d;
            haddr_q    <= haddr_d;
            hburst_q   <= hburst_d;
            hsize_q    <= hsize_d;
            hwrite_q   <= hwrite_d;
            rem_q      <= rem_d;
            seg_left_q <= seg_left_d;
            rphase_q   <= rphase_d;
            wphase_q   <= wphase_d;
        end
    end

    assign bus.HADDR       = haddr_q;
    assign bus.HTRANS      = htrans_q;
    assign bus.HBURST      = hburst_q;
    assign bus.HSIZE       = hsize_q;
    assign bus.HWRITE      = hwrite_q;
    // A completion that coincides with reset is discarded.
    assign bus.ahb_finish  = finish & reset;
    assign bus.rdata_phase = rphase_q;
    assign bus.wdata_phase = wphase_q;
    assign bus.data_last   = data_last;

endmodule

// File: tb/tb_axi2ahb_burst_ctrl.sv
// Bench for axi2ahb_burst_ctrl: expected AHB transfers are queued per
// command and compared as the DUT presents them.
`timescale 1ns/1ps
module tb_axi2ahb_burst_ctrl;
    localparam int AB = 32;
    localparam int LB = 8;
    localparam int MB = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    axi2ahb_burst_ctrl_if #(.ADDR_BITS(AB), .LEN_BITS(LB)) bus ();

    axi2ahb_burst_ctrl #(.ADDR_BITS(AB), .LEN_BITS(LB), .MAX_BEATS(MB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic [1:0]  size;
        logic        wr;
        bit          gap;
    } xfer_t;

    xfer_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    fin_cnt  = 0;
    int    n_cmds   = 0;
    bit    mon_en   = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Expected transfers of one command, including BUSY beats inserted
    // after beat busy_after; keep < 0 means all beats are issued.
    task automatic push_cmd(input bit rd, input logic [31:0] addr, input int len,
                            input int size, input int busy_after, input int busy_n,
                            input int keep);
        int          rem;
        int          to_kb;
        int          seg;
        int          beat;
        bit          first;
        logic [2:0]  burst;
        logic [31:0] a;
        xfer_t       x;
        rem   = len + 1;
        a     = addr;
        beat  = 0;
        first = 1'b1;
        while (rem > 0) begin
            to_kb = (1024 - a[9:0]) >> size;
            if (to_kb == 0) to_kb = 1;
            seg = rem;
            if (seg > MB) seg = MB;
            if (seg > to_kb) seg = to_kb;
            burst = (seg == 1) ? 3'b000 : (seg == 4) ? 3'b011 : (seg == 8) ? 3'b101 :
                    (seg == 16) ? 3'b111 : 3'b001;
            for (int i = 0; i < seg; i++) begin
                if (keep < 0 || beat < keep) begin
                    x.addr  = a;
                    x.trans = (i == 0) ? 2'b10 : 2'b11;
                    x.burst = burst;
                    x.size  = 2'(size);
                    x.wr    = ~rd;
                    x.gap   = (i == 0) && !first;
                    exp_q.push_back(x);
                end
                a = a + (32'd1 << size);
                if (beat == busy_after) begin
                    for (int j = 0; j < busy_n; j++) begin
                        x.addr  = a;
                        x.trans = 2'b01;
                        x.burst = burst;
                        x.size  = 2'(size);
                        x.wr    = ~rd;
                        x.gap   = 1'b0;
                        exp_q.push_back(x);
                    end
                end
                beat++;
            end
            first = 1'b0;
            rem   = rem - seg;
        end
    endtask

    // Monitor: scoreboard compare, hold rule, IDLE gap length.
    logic        prev_valid = 1'b0;
    logic        prev_hready;
    logic [1:0]  prev_trans;
    logic [1:0]  prev_resp;
    logic [36:0] prev_bus;
    int          idle_run = 0;
    bit          exempt;
    xfer_t       e;

    always @(negedge clk) begin
        if (bus.ahb_finish) fin_cnt++;
        if (mon_en && reset) begin
            exempt = 1'b0;
`ifdef AXI2AHB_HRESP_ERR_EN
            exempt = (prev_resp == 2'b01);
`endif
            if (prev_valid && !prev_hready && prev_trans != 2'b00 && !exempt)
                check_eq("hold", {bus.HADDR, bus.HTRANS, bus.HBURST}, prev_bus);
            if (bus.HREADY && bus.HTRANS != 2'b00) begin
                check_eq("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("xfer_addr", bus.HADDR, e.addr);
                    check_eq("xfer_ctrl", {bus.HTRANS, bus.HBURST, bus.HSIZE, bus.HWRITE},
                             {e.trans, e.burst, e.size, e.wr});
                    if (e.gap) check_eq("gap_idle", idle_run, 1);
                end
            end
            idle_run    = (bus.HTRANS == 2'b00) ? idle_run + 1 : 0;
            prev_hready = bus.HREADY;
            prev_trans  = bus.HTRANS;
            prev_resp   = bus.HRESP;
            prev_bus    = {bus.HADDR, bus.HTRANS, bus.HBURST};
            prev_valid  = 1'b1;
        end else begin
            prev_valid = 1'b0;
            idle_run   = 0;
        end
    end

    // Cycle k = 0 presents the command; windows are [start, start+n).
    task automatic run_cmd(input bit rd, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] size, input int hr_s, input int hr_n,
                           input int dr_s, input int dr_n, input int er_s, input int er_n,
                           input bit exp_err);
        bit got_fin;
        got_fin = 1'b0;
        n_cmds++;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                bus.cmd_read  = rd;
                bus.cmd_addr  = addr;
                bus.cmd_len   = len;
                bus.cmd_size  = size;
                bus.cmd_empty = 1'b0;
            end
            bus.HREADY      = !(k >= hr_s && k < hr_s + hr_n);
            bus.rdata_ready = !(k >= dr_s && k < dr_s + dr_n);
            bus.wdata_ready = bus.rdata_ready;
            bus.HRESP       = (k >= er_s && k < er_s + er_n) ? 2'b01 : 2'b00;
            @(negedge clk);
            if (k == 0) check_eq("idle_addr", {bus.HADDR, bus.HTRANS}, 34'h0);
            if (k == 1) check_eq("start_lat", bus.HTRANS, 2'b10);
            if (er_n > 0 && k == er_s + 1) begin
`ifdef AXI2AHB_HRESP_ERR_EN
                check_eq("err_idle", bus.HTRANS, 2'b00);
`else
                check_eq("err_ignored", bus.HTRANS, 2'b11);
`endif
            end
            if (bus.ahb_finish) begin
                got_fin = 1'b1;
                check_eq("cmd_err", bus.cmd_err, exp_err);
                break;
            end
        end
        check_eq("finish_seen", got_fin, 1);
        #1;
        check_eq("beats_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.HREADY      = 1'b1;
        bus.HRESP       = 2'b00;
        bus.cmd_empty   = 1'b1;
        bus.cmd_read    = 1'b0;
        bus.cmd_addr    = '0;
        bus.cmd_len     = '0;
        bus.cmd_size    = '0;
        bus.rdata_ready = 1'b1;
        bus.wdata_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ctrl", {bus.HADDR, bus.HTRANS, bus.HBURST, bus.HSIZE, bus.HWRITE}, 0);
        check_eq("rst_flags", {bus.ahb_finish, bus.cmd_err, bus.rdata_phase, bus.wdata_phase}, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        mon_en = 1'b1;

        // single read
        push_cmd(1, 32'h100, 0, 2, -1, 0, -1);
        run_cmd(1, 32'h100, 8'd0, 2'd2, -1, 0, -1, 0, -1, 0, 1'b0);
        @(posedge clk);
        #1 bus.cmd_empty = 1'b1;
        @(negedge clk);
        check_eq("rphase_set", {bus.rdata_phase, bus.wdata_phase, bus.data_last}, 3'b101);
        @(negedge clk);
        check_eq("rphase_clr", {bus.rdata_phase, bus.wdata_phase}, 2'b00);

        // length split: INCR16, INCR16, INCR8
        push_cmd(0, 32'h0, 39, 2, -1, 0, -1);
        run_cmd(0, 32'h0, 8'd39, 2'd2, -1, 0, -1, 0, -1, 0, 1'b0);

        // 1 KB boundary split
        push_cmd(1, 32'h3F8, 3, 2, -1, 0, -1);
        run_cmd(1, 32'h3F8, 8'd3, 2'd2, -1, 0, -1, 0, -1, 0, 1'b0);

        // mid-burst stall: 3 BUSY after beat 1
        push_cmd(0, 32'h200, 3, 2, 1, 3, -1);
        run_cmd(0, 32'h200, 8'd3, 2'd2, -1, 0, 2, 3, -1, 0, 1'b0);

        // wait states on beat 0 of INCR8
        push_cmd(1, 32'h300, 7, 2, -1, 0, -1);
        run_cmd(1, 32'h300, 8'd7, 2'd2, 1, 2, -1, 0, -1, 0, 1'b0);

        // back-to-back commands
        push_cmd(0, 32'h500, 2, 2, -1, 0, -1);
        run_cmd(0, 32'h500, 8'd2, 2'd2, -1, 0, -1, 0, -1, 0, 1'b0);
        push_cmd(1, 32'h600, 0, 1, -1, 0, -1);
        run_cmd(1, 32'h600, 8'd0, 2'd1, -1, 0, -1, 0, -1, 0, 1'b0);

        // ERROR response on beat 2 of INCR16
`ifdef AXI2AHB_HRESP_ERR_EN
        push_cmd(0, 32'h0, 15, 2, -1, 0, 3);
        run_cmd(0, 32'h0, 8'd15, 2'd2, 4, 1, -1, 0, 4, 2, 1'b1);
`else
        push_cmd(0, 32'h0, 15, 2, -1, 0, -1);
        run_cmd(0, 32'h0, 8'd15, 2'd2, 4, 1, -1, 0, 4, 2, 1'b0);
`endif

        // following command, 8-byte beats across 1 KB
        push_cmd(1, 32'h3F0, 7, 3, -1, 0, -1);
        run_cmd(1, 32'h3F0, 8'd7, 2'd3, -1, 0, -1, 0, -1, 0, 1'b0);

        // full-length command: 256 beats
        push_cmd(0, 32'h800, 255, 0, -1, 0, -1);
        run_cmd(0, 32'h800, 8'd255, 2'd0, -1, 0, -1, 0, -1, 0, 1'b0);

        // reset during the final ack of a command
        @(posedge clk);
        #1 bus.cmd_empty = 1'b1;
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        bus.cmd_read  = 1'b1;
        bus.cmd_addr  = 32'h100;
        bus.cmd_len   = 8'd0;
        bus.cmd_size  = 2'd2;
        bus.cmd_empty = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_nonseq", bus.HTRANS, 2'b10);
        check_eq("rst_no_fin", bus.ahb_finish, 1'b0);
        @(posedge clk);
        #1 bus.cmd_empty = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_state", {bus.HADDR, bus.HTRANS, bus.rdata_phase, bus.wdata_phase}, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_eq("rst_release_idle", bus.HTRANS, 2'b00);

        check_eq("fin_count", fin_cnt, n_cmds);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi2ahb_burst_ctrl.md
# axi2ahb_burst_ctrl

Second-generation AHB master control for the AXI-to-AHB bridge. It takes one queued AXI command at a time and drives the AHB address/control phase. Commands longer than one AHB burst, or crossing a 1 KB boundary, are split into several AHB bursts. It inserts BUSY beats when the data path stalls mid-burst, and aborts on an AHB ERROR response. It sits between the command FIFO and the read/write data paths, replacing the fixed 16-beat control block.

## Interface
- `ADDR_BITS`, 32, HADDR and cmd_addr width.
- `LEN_BITS`, 8, cmd_len width: 4 for AXI3, 8 for AXI4.
- `MAX_BEATS`, 16, largest AHB burst issued; legal values are 4, 8 and 16.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-low.
- `HADDR` output ADDR_BITS: AHB address.
- `HTRANS` output 2: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `HBURST` output 3: SINGLE=000, INCR=001, INCR4=011, INCR8=101, INCR16=111.
- `HSIZE` output 2: beat size, 1/2/4/8 bytes.
- `HWRITE` output 1: 1 = write.
- `HREADY` input 1: slave ready.
- `HRESP` input 2: 00 = OKAY, 01 = ERROR. Other codes are treated as OKAY.
- `cmd_empty` input 1: command FIFO empty.
- `cmd_read` input 1: 1 = read command.
- `cmd_addr` input ADDR_BITS: start address.
- `cmd_len` input LEN_BITS: number of beats minus 1.
- `cmd_size` input 2: beat size code.
- `rdata_ready` input 1: read data path can accept a beat.
- `wdata_ready` input 1: write data path has a beat.
- `ahb_finish` output 1: one-cycle pulse when the command is done; pops the command FIFO.
- `cmd_err` output 1: qualifies `ahb_finish`; the command ended on ERROR.
- `rdata_phase` output 1: a read data phase is outstanding.
- `wdata_phase` output 1: a write data phase is outstanding.
- `data_last` output 1: the last data phase of the current AHB burst completes this cycle.

## Operation
- **States:** IDLE, ADDR (NONSEQ/SEQ issue), STALL (BUSY issue), GAP (one IDLE between split segments), ERR.
- **Definitions:**
  - `data_ready` = cmd_read ? rdata_ready : wdata_ready.
  - `ack` = HTRANS[1] & HREADY.
- **IDLE:**
  - Start when `~cmd_empty & data_ready & (HREADY | ~data_phase)`.
  - On start, latch cmd_read, cmd_size, cmd_addr and remaining beats `rem = cmd_len + 1` (width LEN_BITS+1).
  - Compute the first segment, then go to ADDR with NONSEQ.
- **Segment length** `seg = min(rem, MAX_BEATS, beats_to_1KB)`, where `beats_to_1KB = (1024 - HADDR[9:0]) >> HSIZE`.
- **HBURST per segment:**
  - seg = 1 → SINGLE.
  - seg = 4, 8 or 16 (and ≤ MAX_BEATS) → INCRn.
  - Any other length → INCR.
- **ADDR, on each ack:**
  - HADDR += 1 << HSIZE, computed at full ADDR_BITS width.
  - The beat counter increments; `rem` decrements.
  - Not last beat of the segment: next beat is SEQ if data_ready, otherwise BUSY (go to STALL).
  - Last beat of the segment with `rem > 1`: go to GAP.
  - Last beat of the command: go to IDLE and pulse `ahb_finish`.
- **STALL:** hold HADDR and control with HTRANS = BUSY. Return to SEQ in the cycle after data_ready is seen.
- **GAP:** HTRANS = IDLE for one cycle. Then NONSEQ at the next address with a new seg and HBURST.
- **Phase flags:**
  - `rdata_phase` / `wdata_phase` set on ack according to HWRITE.
  - Cleared when `data_last` is high and no new ack occurs.
  - `data_last = HREADY & (HTRANS==IDLE | HTRANS==NONSEQ)`.
- **Reset mid-operation:** all state returns to IDLE within the same clock edge. No `ahb_finish` is issued.

## Timing
- **Reset values:** HTRANS = IDLE, HBURST = SINGLE, HSIZE = 0, HWRITE = 0, HADDR = 0, all flags 0.
- **Start latency:** NONSEQ is driven in the cycle after the start condition is true.
- **Back-to-back commands:** a new start may be evaluated in the cycle after `ahb_finish`.
- **Hold rule:** HADDR and control are held while HREADY = 0.
- **Completion:** `ahb_finish` is high in the cycle where the last ack occurs. HADDR returns to 0 at the next edge.
- **Simultaneous ack and `~data_ready`:** BUSY wins for the next beat.
- **Simultaneous start and data_last:** the phase flag of the new command takes priority over the clear.
- **Overflow:** `rem` never underflows. With cmd_len = 2^LEN_BITS − 1 there are 2^LEN_BITS beats.

## Configuration
- `AXI2AHB_HRESP_ERR_EN` defined — ERROR abort is enabled:
  - In the first ERROR cycle (HREADY = 0, HRESP = ERROR), HTRANS is driven IDLE next cycle.
  - The remaining beats of the command are dropped and the block goes to ERR.
  - When the second ERROR cycle ends with HREADY = 1, `ahb_finish` and `cmd_err` pulse together.
- Macro undefined — error abort is removed:
  - HRESP is ignored and `cmd_err` is tied to 0.
  - An ERROR beat counts as a normal ack.

## Test plan
- **Single read:** read, cmd_len = 0, addr 0x100, size 2 → one NONSEQ with SINGLE at 0x100; `ahb_finish` on its ack; rdata_phase high for one cycle.
- **Length split:** write, cmd_len = 39, size 2, addr 0x0, MAX_BEATS = 16 → three bursts: INCR16 at 0x0, INCR16 at 0x40, INCR8 at 0x80; one IDLE gap between bursts; `ahb_finish` once.
- **1 KB boundary split:** read, addr 0x3F8, size 2, cmd_len = 3 → INCR burst of 2 at 0x3F8, then INCR burst of 2 at 0x400.
- **Mid-burst stall:** INCR4 write with wdata_ready low for 3 cycles after beat 1 → NONSEQ, SEQ, then 3×BUSY at constant HADDR, then SEQ, SEQ; addresses strictly +4.
- **Wait states:** HREADY low for 2 cycles on beat 0 of INCR8 → HADDR, HTRANS and HBURST held; beat count is still 8.
- **Error abort (macro defined):** ERROR on beat 2 of INCR16 → HTRANS IDLE next cycle; `ahb_finish` = `cmd_err` = 1 after the second ERROR cycle; the next command starts normally.
